// File: rtl/btn_evt_pkg.sv
`default_nettype none
// ============================================================================
// btn_evt_pkg : shared types, widths and helpers for btn_event_arbiter
// Rev 1.0
// ============================================================================
package btn_evt_pkg;

  localparam int DROP_CNT_W     = 8;
  localparam int DEBOUNCE_CNT_W = 16;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  function automatic logic [DROP_CNT_W-1:0] drop_sat_add(
    input logic [DROP_CNT_W-1:0] cnt,
    input logic [DROP_CNT_W-1:0] inc
  );
    logic [DROP_CNT_W:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc};
    return sum[DROP_CNT_W] ? {DROP_CNT_W{1'b1}} : sum[DROP_CNT_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_channel.sv
`default_nettype none
// ============================================================================
// btn_channel : 2-flop synchroniser, counter debounce and edge pulse.
// BTN_RELEASE_EVT_EN: o_evt fires on both edges and o_rise gives the type.
// Rev 1.0
// ============================================================================
module btn_channel
  import btn_evt_pkg::*;
#(
  parameter int DELAY = 160
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_state,
  output logic o_evt
`ifdef BTN_RELEASE_EVT_EN
  ,output logic o_rise
`endif
);

  localparam logic [DEBOUNCE_CNT_W-1:0] c_delay = DEBOUNCE_CNT_W'(DELAY);

  logic                      r_s1;
  logic                      r_s2;
  logic                      r_stable;
  logic                      r_stable_d;
  logic [DEBOUNCE_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= 1'b0;
      r_s2       <= 1'b0;
      r_cnt      <= '0;
      r_stable   <= 1'b0;
      r_stable_d <= 1'b0;
    end else begin
      r_s1       <= i_raw;
      r_s2       <= r_s1;
      r_cnt      <= (r_s2 == r_stable) ? '0 : r_cnt + DEBOUNCE_CNT_W'(1);
      r_stable   <= (r_cnt >= c_delay) ? r_s2 : r_stable;
      r_stable_d <= r_stable;
    end
  end

  assign o_state = r_stable;

`ifdef BTN_RELEASE_EVT_EN
  assign o_rise = r_stable & ~r_stable_d;
  assign o_evt  = r_stable ^ r_stable_d;
`else
  assign o_evt  = r_stable & ~r_stable_d;
`endif

endmodule
`default_nettype wire

// File: rtl/btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// btn_event_arbiter : N debounced buttons, one pending slot each, round-robin
// onto a valid/ready event port. BTN_RELEASE_EVT_EN also queues releases.
// Rev 1.0
// ============================================================================
module btn_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int IDX_W = 2,
  parameter int DELAY = 160
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_BTN-1:0]      btn_raw,
  output logic [N_BTN-1:0]      btn_state,
  output logic                  evt_valid,
  input  logic                  evt_ready,
  output logic [IDX_W-1:0]      evt_idx,
  output logic                  evt_press,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  logic [N_BTN-1:0]      w_evt;
  logic [N_BTN-1:0]      r_pend;
  logic [N_BTN-1:0]      w_clr;
  logic [N_BTN-1:0]      w_take;
  logic [N_BTN-1:0]      w_drop;
  logic [N_BTN-1:0]      w_pend_nxt;
  logic [DROP_CNT_W-1:0] w_ndrop;
  logic [DROP_CNT_W-1:0] r_drop;
  logic [IDX_W-1:0]      r_ptr;
  logic [IDX_W-1:0]      r_idx;
  logic [IDX_W-1:0]      w_sel;
  logic [IDX_W:0]        w_cand;
  logic                  w_found;
  logic                  w_latch;
  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
`ifdef BTN_RELEASE_EVT_EN
  logic [N_BTN-1:0]      w_rise;
  logic [N_BTN-1:0]      r_ptype;
  logic                  r_evt_press;
`endif

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_channel #(
      .DELAY (DELAY)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (btn_raw[i]),
      .o_state (btn_state[i]),
      .o_evt   (w_evt[i])
`ifdef BTN_RELEASE_EVT_EN
      ,.o_rise (w_rise[i])
`endif
    );
  end

  // First pending channel after the pointer, wrapping at N_BTN-1.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_cand  = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
      if (w_cand >= (IDX_W+1)'(N_BTN)) begin
        w_cand = w_cand - (IDX_W+1)'(N_BTN);
      end
      if (!w_found && r_pend[w_cand[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_latch     = 1'b1;
          w_state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // A slot being latched this cycle is free for a same-cycle edge.
  always_comb begin
    w_clr = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_clr[i] = w_latch && (w_sel == IDX_W'(i));
    end
    w_take     = w_evt & (~r_pend | w_clr);
    w_drop     = w_evt & r_pend & ~w_clr;
    w_pend_nxt = w_take | (r_pend & ~w_clr);
    w_ndrop    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      w_ndrop = w_ndrop + DROP_CNT_W'(w_drop[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= IDX_W'(N_BTN - 1);
      r_idx   <= '0;
      r_pend  <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_pend_nxt;
      r_drop  <= drop_sat_add(r_drop, w_ndrop);
      if (w_latch) begin
        r_ptr <= w_sel;
        r_idx <= w_sel;
      end
    end
  end

`ifdef BTN_RELEASE_EVT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptype     <= '0;
      r_evt_press <= 1'b0;
    end else begin
      r_ptype <= (w_take & w_rise) | (~w_take & r_ptype);
      if (w_latch) begin
        r_evt_press <= r_ptype[w_sel];
      end
    end
  end
  assign evt_press = r_evt_press;
`else
  assign evt_press = 1'b1;
`endif

  assign evt_valid = (r_state == OFFER);
  assign evt_idx   = r_idx;
  assign drop_cnt  = r_drop;

endmodule
`default_nettype wire

// File: tb/tb_btn_event_arbiter.sv
`default_nettype none
// ============================================================================
// tb_btn_event_arbiter : directed and random stimulus against a sample-history
// reference model. Honours BTN_RELEASE_EVT_EN. Rev 1.0
// ============================================================================
module tb_btn_event_arbiter;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int DLY = 4;
`ifdef BTN_RELEASE_EVT_EN
  localparam bit REL = 1'b1;
`else
  localparam bit REL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  btn_raw;
  logic [N-1:0]  btn_state;
  logic          evt_valid;
  logic          evt_ready;
  logic [IW-1:0] evt_idx;
  logic          evt_press;
  logic [7:0]    drop_cnt;

  int total = 0;
  int bad   = 0;
  bit done  = 1'b0;
  int seen[$];

  always #5 clk = ~clk;

  btn_event_arbiter #(
    .N_BTN (N),
    .IDX_W (IW),
    .DELAY (DLY)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_raw),
    .btn_state (btn_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_idx   (evt_idx),
    .evt_press (evt_press),
    .drop_cnt  (drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Reference: a level becomes stable once DELAY+1 consecutive synchronised
  // samples disagree with it; events then queue one deep per channel.
  logic [N-1:0] hist [0:DLY+2];
  logic [N-1:0] m_stable, m_sd, m_pend, m_ptype;
  bit           m_valid, m_press;
  int           m_idx, m_ptr, m_drop;

  task automatic model_edge();
    logic [N-1:0] st, sd, pend, pt;
    int  latch;
    bit  all_diff, rise, fall, ev;
    if (rst) begin
      m_stable = '0; m_sd = '0; m_pend = '0; m_ptype = '0;
      m_valid = 1'b0; m_press = 1'b0; m_idx = 0; m_ptr = N - 1; m_drop = 0;
      for (int a = 0; a <= DLY + 2; a++) hist[a] = '0;
      return;
    end
    st = m_stable; sd = m_sd; pend = m_pend; pt = m_ptype; latch = -1;
    if (m_valid) begin
      if (evt_ready) m_valid = 1'b0;
    end else if (pend != '0) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (latch < 0 && pend[j]) latch = j;
      end
      m_idx = latch; m_press = pt[latch]; m_ptr = latch; m_valid = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      rise = st[i] & ~sd[i];
      fall = ~st[i] & sd[i];
      ev   = rise | (REL & fall);
      if (ev) begin
        if (pend[i] && latch != i) begin
          if (m_drop < 255) m_drop++;
        end else begin
          m_pend[i] = 1'b1;
          m_ptype[i] = rise;
        end
      end else if (latch == i) begin
        m_pend[i] = 1'b0;
      end
    end
    m_sd = st;
    for (int a = DLY + 2; a > 0; a--) hist[a] = hist[a-1];
    hist[0] = btn_raw;
    for (int i = 0; i < N; i++) begin
      all_diff = 1'b1;
      for (int a = 2; a <= DLY + 2; a++) if (hist[a][i] == st[i]) all_diff = 1'b0;
      if (all_diff) m_stable[i] = ~st[i];
    end
  endtask

  initial begin
    while (!done) begin
      @(posedge clk);
      model_edge();
      #1;
      chk("btn_state", btn_state, m_stable);
      chk("evt_valid", evt_valid, m_valid);
      chk("drop_cnt", drop_cnt, m_drop);
      if (m_valid) begin
        chk("evt_idx", evt_idx, m_idx);
        chk("evt_press", evt_press, m_press);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic collect(input int n);
    seen.delete();
    repeat (n) begin
      step();
      if (evt_valid === 1'b1 && evt_press === 1'b1) seen.push_back(int'(evt_idx));
    end
  endtask

  int nv;
  int rem [N];

  initial begin
    rst = 1'b1; btn_raw = '0; evt_ready = 1'b0;
    step(); step();
    chk("rst_valid", evt_valid, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_state", btn_state, 0);

    // single press on channel 1, edge 0 is the first edge after this point
    rst = 1'b0; evt_ready = 1'b1; btn_raw[1] = 1'b1;
    for (int e = 0; e <= 9; e++) begin
      step();
      if (e == 5) chk("press_state_e5", btn_state[1], 0);
      if (e == 6) chk("press_state_e6", btn_state[1], 1);
      if (e == 7) chk("press_valid_e7", evt_valid, 0);
      if (e == 8) begin
        chk("press_valid_e8", evt_valid, 1);
        chk("press_idx_e8", evt_idx, 1);
        chk("press_type_e8", evt_press, 1);
      end
      if (e == 9) chk("press_valid_e9", evt_valid, 0);
    end
    repeat (10) step();
    btn_raw[1] = 1'b0;
    repeat (20) step();

    // glitch shorter than the debounce window
    btn_raw[0] = 1'b1;
    nv = 0;
    repeat (3) begin step(); if (evt_valid) nv++; end
    btn_raw[0] = 1'b0;
    repeat (20) begin step(); if (evt_valid) nv++; end
    chk("glitch_state", btn_state, 0);
    chk("glitch_evts", nv, 0);
    chk("glitch_drop", drop_cnt, 0);

    // round robin from a fresh pointer
    rst = 1'b1; step(); rst = 1'b0;
    btn_raw = 4'b1101;
    collect(30);
    chk("rr1_len", seen.size(), 3);
    if (seen.size() >= 3) begin
      chk("rr1_first", seen[0], 0);
      chk("rr1_second", seen[1], 2);
      chk("rr1_third", seen[2], 3);
    end
    btn_raw = '0;
    repeat (30) step();
    btn_raw = 4'b1001;
    collect(30);
    chk("rr2_len", seen.size(), 2);
    if (seen.size() >= 2) begin
      chk("rr2_first", seen[0], 0);
      chk("rr2_second", seen[1], 3);
    end
    btn_raw = '0;
    repeat (30) step();

    // backpressure: press then release on channel 2 while the port is stalled
    rst = 1'b1; step(); rst = 1'b0;
    evt_ready = 1'b0;
    btn_raw[2] = 1'b1;
    repeat (15) step();
    btn_raw[2] = 1'b0;
    repeat (35) step();
    chk("bp_valid", evt_valid, 1);
    chk("bp_idx", evt_idx, 2);
    chk("bp_type", evt_press, 1);
    chk("bp_drop", drop_cnt, 0);
    evt_ready = 1'b1;
    nv = 0;
    repeat (20) begin step(); if (evt_valid) nv++; end
    chk("bp_more_evts", nv, REL ? 1 : 0);

    // drop counter saturation
    rst = 1'b1; step(); rst = 1'b0;
    evt_ready = 1'b0;
    for (int s = 0; s < 1400; s++) begin
      if (s % 7 == 0) btn_raw = ~btn_raw;
      step();
    end
    chk("sat_drop", drop_cnt, 255);

    // reset while an event is offered, buttons held through it
    btn_raw = '1;
    repeat (20) step();
    chk("offer_before_rst", evt_valid, 1);
    rst = 1'b1; step();
    chk("offer_rst_valid", evt_valid, 0);
    chk("offer_rst_drop", drop_cnt, 0);
    chk("offer_rst_state", btn_state, 0);
    rst = 1'b0; evt_ready = 1'b1;
    for (int e = 0; e <= 8; e++) begin
      step();
      if (e == 7) chk("reissue_valid_e7", evt_valid, 0);
      if (e == 8) begin
        chk("reissue_valid_e8", evt_valid, 1);
        chk("reissue_idx_e8", evt_idx, 0);
      end
    end

    // random phase: run lengths never equal DLY+1
    for (int i = 0; i < N; i++) rem[i] = 10;
    repeat (2500) begin
      for (int i = 0; i < N; i++) begin
        if (rem[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          rem[i] = ($urandom % 2 == 0) ? int'($urandom_range(1, DLY))
                                       : int'($urandom_range(DLY + 2, DLY + 12));
        end
      end
      evt_ready = ($urandom % 2 == 0);
      step();
      for (int i = 0; i < N; i++) rem[i]--;
    end

    done = 1'b1;
    step(); step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
